// File: rtl/pulp_clock_gate_ctrl.sv
// Per-domain clock-gate enable sequencer.
// Gates each domain after an idle interval, wakes it with a settle delay.
//
// Ports:
//   clk_i, rst_ni       always-on clock, async active-low reset
//   test_en_i           scan mode, forces every clk_en_o high
//   cfg_idle_thresh_i   shared idle threshold, 0 disables gating
//   busy_i              per-domain activity (blocks gating, wakes)
//   force_on_i          per-domain software keep-on
//   wake_req_i          per-domain level wake request
//   clk_en_o            registered gate enable (ORed with test_en_i)
//   clk_ready_o         clock running and settled (ON, COUNT)
//   gated_o             clock stopped (OFF)
module pulp_clock_gate_ctrl #(
  parameter int unsigned NUM_DOMAINS   = 4,
  parameter int unsigned IDLE_CNT_W    = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_en_i,
  input  logic [IDLE_CNT_W-1:0]  cfg_idle_thresh_i,
  input  logic [NUM_DOMAINS-1:0] busy_i,
  input  logic [NUM_DOMAINS-1:0] force_on_i,
  input  logic [NUM_DOMAINS-1:0] wake_req_i,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic [NUM_DOMAINS-1:0] clk_ready_o,
  output logic [NUM_DOMAINS-1:0] gated_o
);

  localparam int unsigned SW =
    (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SET_ONE  = SW'(1);
  localparam logic [SW-1:0] SET_ZERO = '0;

  localparam logic [IDLE_CNT_W-1:0] IDLE_ONE  = IDLE_CNT_W'(1);
  localparam logic [IDLE_CNT_W-1:0] IDLE_ZERO = '0;

  localparam logic [1:0] S_ON    = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_OFF   = 2'd2;
  localparam logic [1:0] S_WAKE  = 2'd3;

  logic [NUM_DOMAINS-1:0] keep;
  logic [NUM_DOMAINS-1:0] en_q;
  logic [NUM_DOMAINS-1:0] ready_q;
  logic [NUM_DOMAINS-1:0] gated_q;
  logic                   thresh_zero;

  assign keep        = busy_i | force_on_i | wake_req_i;
  assign thresh_zero = (cfg_idle_thresh_i == IDLE_ZERO);

  // Scan override is the only combinational path to an output.
  assign clk_en_o    = en_q | {NUM_DOMAINS{test_en_i}};
  assign clk_ready_o = ready_q;
  assign gated_o     = gated_q;

  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom

    logic [1:0]            st_q;
    logic [1:0]            st_d;
    logic [IDLE_CNT_W-1:0] idle_q;
    logic [IDLE_CNT_W-1:0] idle_d;
    logic [SW-1:0]         set_q;
    logic [SW-1:0]         set_d;
    logic                  en_r;
    logic                  ready_r;
    logic                  gated_r;
    logic                  en_d;
    logic                  ready_d;
    logic                  gated_d;

    always_comb begin
      st_d   = st_q;
      idle_d = idle_q;
      set_d  = set_q;
      unique case (st_q)
        S_ON: begin
          if (!keep[d] && !thresh_zero) begin
            st_d   = S_COUNT;
            idle_d = IDLE_ONE;
          end
        end
        S_COUNT: begin
          // keep has priority over reaching the threshold.
          // Live threshold: lowering it gates on the next edge.
          if (keep[d] || thresh_zero) begin
            st_d   = S_ON;
            idle_d = IDLE_ZERO;
          end else if (idle_q >= cfg_idle_thresh_i) begin
            st_d   = S_OFF;
            idle_d = IDLE_ZERO;
          end else begin
            idle_d = idle_q + IDLE_ONE;
          end
        end
        S_OFF: begin
          if (keep[d]) begin
            st_d  = S_WAKE;
            set_d = SET_ONE;
          end
        end
        S_WAKE: begin
          // Wake always completes; keep is re-evaluated from ON.
          if (set_q == SETTLE_V) begin
            st_d  = S_ON;
            set_d = SET_ZERO;
          end else begin
            set_d = set_q + SET_ONE;
          end
        end
        default: begin
          st_d   = S_ON;
          idle_d = IDLE_ZERO;
          set_d  = SET_ZERO;
        end
      endcase
    end

    // Outputs are flops loaded from the next state so they
    // are glitch-free and take their reset value at once.
    always_comb begin
      en_d    = (st_d != S_OFF);
      ready_d = (st_d == S_ON) || (st_d == S_COUNT);
      gated_d = (st_d == S_OFF);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q    <= S_ON;
        idle_q  <= IDLE_ZERO;
        set_q   <= SET_ZERO;
        en_r    <= 1'b1;
        ready_r <= 1'b1;
        gated_r <= 1'b0;
      end else begin
        st_q    <= st_d;
        idle_q  <= idle_d;
        set_q   <= set_d;
        en_r    <= en_d;
        ready_r <= ready_d;
        gated_r <= gated_d;
      end
    end

    assign en_q[d]    = en_r;
    assign ready_q[d] = ready_r;
    assign gated_q[d] = gated_r;

  end

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Directed testbench for pulp_clock_gate_ctrl.
// Default parameters: 4 domains, 8-bit idle count, settle of 2.
module tb_pulp_clock_gate_ctrl;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         test_en;
  logic [W-1:0] thresh;
  logic [N-1:0] busy;
  logic [N-1:0] force_on;
  logic [N-1:0] wake_req;
  logic [N-1:0] clk_en;
  logic [N-1:0] ready;
  logic [N-1:0] gated;

  int errors = 0;
  int checks = 0;

  pulp_clock_gate_ctrl #(
    .NUM_DOMAINS  (N),
    .IDLE_CNT_W   (W),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .test_en_i        (test_en),
    .cfg_idle_thresh_i(thresh),
    .busy_i           (busy),
    .force_on_i       (force_on),
    .wake_req_i       (wake_req),
    .clk_en_o         (clk_en),
    .clk_ready_o      (ready),
    .gated_o          (gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bring an OFF domain back to ON (edge m WAKE, m+2 ON).
  task automatic wake_dom(input int d);
    wake_req[d] = 1'b1;
    tick();
    wake_req[d] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    test_en  = 1'b0;
    thresh   = 8'd4;
    busy     = '0;
    force_on = '0;
    wake_req = '0;
    #12;
    checks++;
    if (clk_en !== 4'hF || ready !== 4'hF || gated !== 4'h0) begin
      errors++;
      $display("FAIL reset_vals en=%h rdy=%h gated=%h need F F 0",
               clk_en, ready, gated);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (clk_en !== 4'hF || gated !== 4'h0) begin
        errors++;
        $display("FAIL idle_edge%0d en=%h gated=%h need F 0",
                 i, clk_en, gated);
      end
    end
    tick();
    checks++;
    if (clk_en !== 4'h0 || gated !== 4'hF || ready !== 4'h0) begin
      errors++;
      $display("FAIL gate_5th en=%h gated=%h rdy=%h need 0 F 0",
               clk_en, gated, ready);
    end
  endtask

  task automatic test_wake();
    wake_req[1] = 1'b1;
    tick();
    wake_req[1] = 1'b0;
    checks++;
    if (clk_en !== 4'h2 || gated !== 4'hD || ready !== 4'h0) begin
      errors++;
      $display("FAIL wake_m en=%h gated=%h rdy=%h need 2 D 0",
               clk_en, gated, ready);
    end
    tick();
    checks++;
    if (ready !== 4'h0 || clk_en !== 4'h2) begin
      errors++;
      $display("FAIL wake_m1 rdy=%h en=%h need 0 2", ready, clk_en);
    end
    tick();
    checks++;
    if (ready !== 4'h2 || clk_en !== 4'h2) begin
      errors++;
      $display("FAIL wake_m2 rdy=%h en=%h need 2 2", ready, clk_en);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (gated !== 4'hF || clk_en !== 4'h0) begin
      errors++;
      $display("FAIL regate gated=%h en=%h need F 0", gated, clk_en);
    end
  endtask

  task automatic test_abort();
    thresh = 8'd3;
    wake_dom(0);
    tick();
    busy[0] = 1'b1;
    tick();
    checks++;
    if (clk_en[0] !== 1'b1 || ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_on en=%b rdy=%b need 1 1",
               clk_en[0], ready[0]);
    end
    tick();
    busy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (clk_en[0] !== 1'b1) begin
        errors++;
        $display("FAIL abort_full%0d en=%b need 1", i, clk_en[0]);
      end
    end
    tick();
    checks++;
    if (clk_en[0] !== 1'b0 || gated[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_gate en=%b gated=%b need 0 1",
               clk_en[0], gated[0]);
    end
  endtask

  task automatic test_thresh_change();
    thresh = 8'd10;
    wake_dom(0);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (clk_en[0] !== 1'b1 || gated[0] !== 1'b0) begin
      errors++;
      $display("FAIL cnt5 en=%b gated=%b need 1 0",
               clk_en[0], gated[0]);
    end
    thresh = 8'd2;
    tick();
    checks++;
    if (gated[0] !== 1'b1 || clk_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL lower_gate gated=%b en=%b need 1 0",
               gated[0], clk_en[0]);
    end
    thresh = 8'd10;
    wake_dom(0);
    tick();
    tick();
    thresh = 8'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (gated[0] !== 1'b0 || ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL thr0_%0d gated=%b rdy=%b need 0 1",
                 i, gated[0], ready[0]);
      end
    end
  endtask

  task automatic test_scan();
    thresh = 8'd1;
    tick();
    tick();
    checks++;
    if (gated !== 4'hF) begin
      errors++;
      $display("FAIL all_off gated=%h need F", gated);
    end
    test_en = 1'b1;
    #1;
    checks++;
    if (clk_en !== 4'hF || gated !== 4'hF) begin
      errors++;
      $display("FAIL scan_on en=%h gated=%h need F F", clk_en, gated);
    end
    tick();
    checks++;
    if (gated !== 4'hF || ready !== 4'h0 || clk_en !== 4'hF) begin
      errors++;
      $display("FAIL scan_hold gated=%h rdy=%h en=%h need F 0 F",
               gated, ready, clk_en);
    end
    test_en = 1'b0;
    #1;
    checks++;
    if (clk_en !== 4'h0 || gated !== 4'hF) begin
      errors++;
      $display("FAIL scan_off en=%h gated=%h need 0 F", clk_en, gated);
    end
  endtask

  task automatic test_keep_wins();
    thresh = 8'd2;
    wake_dom(3);
    tick();
    tick();
    busy[3] = 1'b1;
    tick();
    busy[3] = 1'b0;
    checks++;
    if (gated[3] !== 1'b0 || ready[3] !== 1'b1 || clk_en[3] !== 1'b1) begin
      errors++;
      $display("FAIL keep_wins gated=%b rdy=%b en=%b need 0 1 1",
               gated[3], ready[3], clk_en[3]);
    end
  endtask

  task automatic test_reset_mid_wake();
    wake_req[2] = 1'b1;
    tick();
    wake_req[2] = 1'b0;
    checks++;
    if (clk_en[2] !== 1'b1 || ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_wake en=%b rdy=%b need 1 0",
               clk_en[2], ready[2]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (clk_en !== 4'hF || ready !== 4'hF || gated !== 4'h0) begin
      errors++;
      $display("FAIL async_rst en=%h rdy=%h gated=%h need F F 0",
               clk_en, ready, gated);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_wake();
    test_abort();
    test_thresh_change();
    test_scan();
    test_keep_wins();
    test_reset_mid_wake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulp_clock_gate_ctrl.md
# pulp_clock_gate_ctrl

Per-domain clock-gating controller that sequences the enable inputs of the clock gates in front of up to NUM_DOMAINS clock domains. Each domain runs its own small state machine: it gates the clock after a programmable idle interval and wakes it on request, with a settle delay and a level ready/request handshake. It sits in the SoC clock/power control block, next to the gating cells whose enables it drives. `test_en_i` overrides all gating for scan.

## Interface
- NUM_DOMAINS, 4, number of independently gated domains (1..32)
- IDLE_CNT_W, 8, width of idle threshold and idle counter
- SETTLE_CYCLES, 2, cycles after clock re-enable before ready is reported (>=1)

- clk_i  in  1  always-on controller clock
- rst_ni  in  1  asynchronous active-low reset
- test_en_i  in  1  scan/test mode; forces every clk_en_o to 1
- cfg_idle_thresh_i  in  IDLE_CNT_W  idle cycles before gating, shared by all domains; 0 = gating disabled
- busy_i  in  NUM_DOMAINS  domain activity; 1 blocks gating and wakes a gated domain
- force_on_i  in  NUM_DOMAINS  software override; 1 keeps or brings the domain on
- wake_req_i  in  NUM_DOMAINS  level request from a requester needing the domain clocked
- clk_en_o  out  NUM_DOMAINS  registered gate enable per domain (ORed with test_en_i)
- clk_ready_o  out  NUM_DOMAINS  1 = clock running and settled (states ON, COUNT)
- gated_o  out  NUM_DOMAINS  1 = domain clock stopped (state OFF)

## Operation
- Per domain, `keep = busy_i | force_on_i | wake_req_i`.
- Per-domain FSM states: ON, COUNT, OFF, WAKE. Reset state is ON.
  - ON: clk_en=1, ready=1.
    - If `!keep && thresh!=0`, go to COUNT with cnt=1.
  - COUNT: clk_en=1, ready=1.
    - If keep, go to ON and clear cnt.
    - Else if thresh==0, go to ON.
    - Else if `cnt >= thresh`, go to OFF.
    - Else cnt++.
    - The comparison uses the live cfg value, so lowering the threshold mid-count gates on the next edge.
  - OFF: clk_en=0, ready=0, gated=1.
    - If keep, go to WAKE with settle cnt=1.
  - WAKE: clk_en=1, ready=0.
    - When settle cnt == SETTLE_CYCLES, go to ON; else increment.
    - keep is ignored in WAKE; the domain always completes the wake and then re-evaluates from ON.
- Handshake: the requester holds wake_req_i high until it samples clk_ready_o=1. While wake_req_i stays high the domain cannot leave ON.
  - Dropping wake_req_i before ready is legal. The wake still completes, then normal idle counting resumes.
- Domains are fully independent. There is no arbitration and no shared counter.
- test_en_i only ORs into clk_en_o. FSM state, counters, clk_ready_o and gated_o are unaffected.
- Reset (async assert, any state): state ON, counters 0, clk_en_o all 1, clk_ready_o all 1, gated_o all 0. Deassertion is synchronised externally.
- Counter width: idle counter is IDLE_CNT_W bits; settle counter is clog2(SETTLE_CYCLES+1) bits. Because of the >= compare, neither counter can wrap.

## Timing
- All outputs are registered from FSM state, with no combinational input-to-output path except test_en_i into clk_en_o.
- Gating latency: idle first sampled at edge k (state ON) gives clk_en_o=0 and gated_o=1 after edge k+thresh.
  - Any keep seen at edges k+1..k+thresh-1 aborts, and the domain is back in ON with ready=1 after that edge.
- Wake latency: keep sampled in OFF at edge m gives clk_en_o=1 after edge m, and clk_ready_o=1 after edge m+SETTLE_CYCLES.
- Simultaneous keep and reaching threshold at the same edge: keep wins, go to ON.
- Reset mid-WAKE or mid-COUNT: outputs return to reset values immediately, with no glitch to 0 on clk_en_o.

## Test plan
- Reset with thresh=4, all inputs 0: clk_en_o=F, ready=F, gated=0. Release reset: all domains show clk_en_o=0 and gated=F after the 5th edge (enter COUNT at the 1st edge, OFF 4 edges later).
- Domain 1 gated, pulse wake_req_i[1] at edge m, SETTLE_CYCLES=2: clk_en_o[1]=1 after m, clk_ready_o[1]=1 after m+2, gated_o[1]=0 after m.
- thresh=3, busy_i[0] rises at the 2nd COUNT edge: domain 0 back in ON, cnt cleared, clk_en_o[0] never drops. A later idle period gates after a full 3 edges.
- thresh changed 10→2 while cnt=5: domain gates on the next edge. thresh set to 0 while in COUNT: returns to ON and never gates.
- test_en_i=1 with all domains OFF: clk_en_o=F while gated_o stays F. test_en_i=0: clk_en_o back to 0 with no state change.
- Assert rst_ni low mid-WAKE on domain 2: clk_en_o[2]=1, ready=1, gated=0 asynchronously, before the next clock edge.
